// File: rtl/lc3_console_io.sv
`default_nettype none
// ============================================================================
// Module   : lc3_console_io
// Purpose  : Memory-mapped console controller for the LC-3 multicycle core.
//            Decodes the four LC-3 device registers (KBSR, KBDR, DSR, DDR) on
//            the MAR/DATA bus. Keystrokes are latched from a valid/ready
//            handshake. Display characters queue in a small FIFO and are
//            serialised onto an 8N1 transmit line.
// Ports    : CLK, RESET        - clock, synchronous active-high reset
//            ADDR, WDATA       - MAR address and store data
//            MEM_WE, RD_STROBE - write strobe and read-commit strobe
//            IO_SEL, RDATA     - combinational decode and read data
//            KB_VALID, KB_DATA - offered keyboard byte
//            KB_READY          - registered; high while the keyboard buffer is empty
//            TXD               - serial transmit line, idle high
// Revision : 1.0 - initial release
// ============================================================================
module lc3_console_io #(
    parameter logic [15:0] BASE_ADDR    = 16'hFE00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] ADDR,
    input  logic [15:0] WDATA,
    input  logic        MEM_WE,
    input  logic        RD_STROBE,
    output logic        IO_SEL,
    output logic [15:0] RDATA,
    input  logic        KB_VALID,
    input  logic [7:0]  KB_DATA,
    output logic        KB_READY,
    output logic        TXD
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // The count must represent 0..FIFO_DEPTH inclusive.
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

    localparam logic [15:0] c_KBSR_ADDR = BASE_ADDR;
    localparam logic [15:0] c_KBDR_ADDR = BASE_ADDR + 16'd2;
    localparam logic [15:0] c_DSR_ADDR  = BASE_ADDR + 16'd4;
    localparam logic [15:0] c_DDR_ADDR  = BASE_ADDR + 16'd6;

    // ------------------------------------------------------------------------
    // Transmit state encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    tx_state_t            r_state;
    logic [c_BAUD_W-1:0]  r_baud;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_txd;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 r_kb_full;
    logic                 r_kb_ready;
    logic [7:0]           r_kb_byte;
    logic                 r_ovf;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic w_sel_kbsr;
    logic w_sel_kbdr;
    logic w_sel_dsr;
    logic w_sel_ddr;
    logic w_io_sel;

    assign w_sel_kbsr = (ADDR == c_KBSR_ADDR);
    assign w_sel_kbdr = (ADDR == c_KBDR_ADDR);
    assign w_sel_dsr  = (ADDR == c_DSR_ADDR);
    assign w_sel_ddr  = (ADDR == c_DDR_ADDR);
    assign w_io_sel   = w_sel_kbsr | w_sel_kbdr | w_sel_dsr | w_sel_ddr;

    // ------------------------------------------------------------------------
    // FIFO status and control
    // ------------------------------------------------------------------------
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_tx_idle;
    logic       w_ddr_write;
    logic       w_push;
    logic       w_pop;
    logic       w_baud_done;
    logic [7:0] w_fifo_head;
    logic [2:0] w_next_bit;

    assign w_fifo_full  = (r_count == c_CNT_FULL);
    assign w_fifo_empty = (r_count == '0);
    assign w_tx_idle    = w_fifo_empty & (r_state == ST_IDLE);
    assign w_baud_done  = (r_baud == c_BAUD_MAX);
    assign w_fifo_head  = r_mem[r_rd_ptr];
    assign w_next_bit   = r_bit_idx + 3'd1;

    assign w_ddr_write  = MEM_WE & w_sel_ddr;
    // Full is judged on the pre-edge count: a pop in the same cycle does not
    // make room for this write.
    assign w_push       = w_ddr_write & ~w_fifo_full;
    // The FSM pulls the next byte either from IDLE or at the very end of a
    // stop bit, which gives back-to-back frames with no idle gap.
    assign w_pop        = ~w_fifo_empty &
                          ((r_state == ST_IDLE) |
                           ((r_state == ST_STOP) & w_baud_done));

    // ------------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= WDATA[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Transmit FSM. TXD is registered and changes together with the state,
    // so every bit (start, data, stop) is held for exactly CLKS_PER_BIT cycles.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud <= '0;
                    r_txd  <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_fifo_head;
                        r_state <= ST_START;
                        r_txd   <= 1'b0;
                    end
                end

                ST_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= ST_DATA;
                        r_txd     <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end

                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            // LSB first: the bit index selects the next bit
                            // straight out of the held byte.
                            r_bit_idx <= w_next_bit;
                            r_txd     <= r_shift[w_next_bit];
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end

                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_fifo_head;
                            r_state <= ST_START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_baud  <= '0;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Keyboard buffer and overflow flag
    // ------------------------------------------------------------------------
    logic w_kb_capture;
    logic w_kb_clear;
    logic w_ovf_clear;

    // Capture and clear are mutually exclusive: while the buffer is full the
    // ready flop is already low, so no capture can be accepted.
    assign w_kb_capture = KB_VALID & r_kb_ready;
    assign w_kb_clear   = RD_STROBE & w_sel_kbdr;
    assign w_ovf_clear  = MEM_WE & w_sel_dsr & WDATA[0];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_kb_full  <= 1'b0;
            r_kb_ready <= 1'b1;
            r_kb_byte  <= 8'd0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_kb_capture) begin
                r_kb_byte  <= KB_DATA;
                r_kb_full  <= 1'b1;
                r_kb_ready <= 1'b0;
            end else if (w_kb_clear) begin
                r_kb_full  <= 1'b0;
                r_kb_ready <= 1'b1;
            end

            if (w_ddr_write & w_fifo_full) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clear) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read mux. DDR is write-only and reads as zero.
    // ------------------------------------------------------------------------
    logic [15:0] w_rdata;

    always_comb begin
        w_rdata = 16'h0000;
        if (w_sel_kbsr) begin
            w_rdata = {r_kb_full, 15'b0};
        end else if (w_sel_kbdr) begin
            w_rdata = {8'b0, r_kb_byte};
        end else if (w_sel_dsr) begin
            w_rdata = {~w_fifo_full, w_tx_idle, 13'b0, r_ovf};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign IO_SEL   = w_io_sel;
    assign RDATA    = w_rdata;
    assign KB_READY = r_kb_ready;
    assign TXD      = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_lc3_console_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_console_io
// Purpose  : Directed self-checking bench for lc3_console_io: register map,
//            single and back-to-back serial frames, FIFO overflow, keyboard
//            handshake, mid-frame reset and unmapped addresses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_console_io;

    localparam int          CPB  = 16;
    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;
    localparam logic [15:0] DSR  = 16'hFE04;
    localparam logic [15:0] DDR  = 16'hFE06;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] ADDR = 16'h0000;
    logic [15:0] WDATA = 16'h0000;
    logic        MEM_WE = 1'b0;
    logic        RD_STROBE = 1'b0;
    logic        IO_SEL;
    logic [15:0] RDATA;
    logic        KB_VALID = 1'b0;
    logic [7:0]  KB_DATA = 8'h00;
    logic        KB_READY;
    logic        TXD;

    int errors = 0;
    int checks = 0;

    lc3_console_io #(
        .BASE_ADDR   (16'hFE00),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ADDR     (ADDR),
        .WDATA    (WDATA),
        .MEM_WE   (MEM_WE),
        .RD_STROBE(RD_STROBE),
        .IO_SEL   (IO_SEL),
        .RDATA    (RDATA),
        .KB_VALID (KB_VALID),
        .KB_DATA  (KB_DATA),
        .KB_READY (KB_READY),
        .TXD      (TXD)
    );

    always #5 CLK = ~CLK;

    // Combinational read at the current (negedge) time.
    task automatic read_reg(input logic [15:0] a, output logic [15:0] d);
        ADDR = a;
        #1;
        d = RDATA;
    endtask

    // Called at a negedge; the write lands on the following posedge and the
    // task returns at the negedge after it.
    task automatic write_reg(input logic [15:0] a, input logic [15:0] d);
        ADDR   = a;
        WDATA  = d;
        MEM_WE = 1'b1;
        @(negedge CLK);
        MEM_WE = 1'b0;
    endtask

    // pos is the current negedge relative to the first negedge with the start
    // bit on the line. Start is checked in its first cycle, data bits at their
    // midpoints, stop in its last cycle (pos = 10*CPB-1); returns there.
    task automatic check_frame(input string name, input logic [7:0] exp_byte,
                               input int start_pos);
        int pos;
        int at;
        logic [9:0] bits;
        pos  = start_pos;
        bits = {1'b1, exp_byte, 1'b0};
        for (int k = 0; k < 10; k++) begin
            at = (k == 0) ? 0 : (k == 9) ? (10 * CPB - 1) : (CPB * k + CPB / 2);
            while (pos < at) begin
                @(negedge CLK);
                pos++;
            end
            checks++;
            if (TXD !== bits[k]) begin
                errors++;
                $display("FAIL %s bit%0d: TXD=%b expected %b", name, k, TXD, bits[k]);
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic [15:0] exp_vals [4];
        logic [15:0] addrs [4];
        exp_vals = '{16'h0000, 16'h0000, 16'hC000, 16'h0000};
        addrs    = '{KBSR, KBDR, DSR, DDR};
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            read_reg(addrs[i], d);
            checks++;
            if (d !== exp_vals[i] || IO_SEL !== 1'b1) begin
                errors++;
                $display("FAIL reset_read %h: RDATA=%h IO_SEL=%b expected %h/1",
                         addrs[i], d, IO_SEL, exp_vals[i]);
            end
        end
        checks++;
        if (TXD !== 1'b1 || KB_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: TXD=%b KB_READY=%b expected 1/1", TXD, KB_READY);
        end
    endtask

    task automatic test_unmapped();
        logic [15:0] d;
        logic [15:0] addrs [2];
        int low;
        addrs = '{16'hFE01, 16'h3000};
        for (int i = 0; i < 2; i++) begin
            ADDR      = addrs[i];
            WDATA     = 16'h0041;
            MEM_WE    = 1'b1;
            RD_STROBE = 1'b1;
            #1;
            checks++;
            if (IO_SEL !== 1'b0 || RDATA !== 16'h0000) begin
                errors++;
                $display("FAIL unmapped %h: IO_SEL=%b RDATA=%h expected 0/0000",
                         addrs[i], IO_SEL, RDATA);
            end
            @(negedge CLK);
            MEM_WE    = 1'b0;
            RD_STROBE = 1'b0;
        end
        low = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (TXD !== 1'b1) low++;
        end
        read_reg(DSR, d);
        checks++;
        if (d !== 16'hC000 || low != 0) begin
            errors++;
            $display("FAIL unmapped_state: DSR=%h low_cycles=%0d expected C000/0", d, low);
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] d;
        write_reg(DDR, 16'h0041);
        // One edge after the write: byte queued, not yet popped.
        read_reg(DSR, d);
        checks++;
        if (TXD !== 1'b1 || d !== 16'h8000) begin
            errors++;
            $display("FAIL single_queued: TXD=%b DSR=%h expected 1/8000", TXD, d);
        end
        check_frame("single", 8'h41, -1);
        read_reg(DSR, d);
        checks++;
        if (d !== 16'h8000) begin
            errors++;
            $display("FAIL single_stop_dsr: DSR=%h expected 8000", d);
        end
        @(negedge CLK);
        read_reg(DSR, d);
        checks++;
        if (d !== 16'hC000 || TXD !== 1'b1) begin
            errors++;
            $display("FAIL single_done: DSR=%h TXD=%b expected C000/1", d, TXD);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        ADDR   = DDR;
        MEM_WE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            WDATA = 16'h0030 + 16'(i);
            @(negedge CLK);
        end
        MEM_WE = 1'b0;
        // 0x30 popped on the second write edge; four edges have passed since.
        read_reg(DSR, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL b2b_overflow_dsr: DSR=%h expected 0001", d);
        end
        for (int i = 0; i < 5; i++) begin
            check_frame("b2b", 8'h30 + 8'(i), (i == 0) ? 4 : 0);
            @(negedge CLK);
            checks++;
            if (TXD !== ((i == 4) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL b2b_gap frame%0d: TXD=%b expected %b",
                         i, TXD, (i == 4) ? 1'b1 : 1'b0);
            end
        end
        repeat (CPB) @(negedge CLK);
        read_reg(DSR, d);
        checks++;
        if (d !== 16'hC001 || TXD !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drained: DSR=%h TXD=%b expected C001/1", d, TXD);
        end
        write_reg(DSR, 16'h0000);
        read_reg(DSR, d);
        checks++;
        if (d !== 16'hC001) begin
            errors++;
            $display("FAIL ovf_keep: DSR=%h expected C001", d);
        end
        write_reg(DSR, 16'h0001);
        read_reg(DSR, d);
        checks++;
        if (d !== 16'hC000) begin
            errors++;
            $display("FAIL ovf_clear: DSR=%h expected C000", d);
        end
    endtask

    task automatic test_keyboard();
        logic [15:0] s;
        logic [15:0] b;
        KB_VALID = 1'b1;
        KB_DATA  = 8'h5A;
        @(negedge CLK);
        KB_VALID = 1'b0;
        read_reg(KBSR, s);
        read_reg(KBDR, b);
        checks++;
        if (KB_READY !== 1'b0 || s !== 16'h8000 || b !== 16'h005A) begin
            errors++;
            $display("FAIL kb_capture: READY=%b KBSR=%h KBDR=%h expected 0/8000/005A",
                     KB_READY, s, b);
        end
        KB_VALID = 1'b1;
        KB_DATA  = 8'h33;
        @(negedge CLK);
        KB_VALID = 1'b0;
        write_reg(KBDR, 16'h0077);
        write_reg(KBSR, 16'h0000);
        read_reg(KBSR, s);
        read_reg(KBDR, b);
        checks++;
        if (KB_READY !== 1'b0 || s !== 16'h8000 || b !== 16'h005A) begin
            errors++;
            $display("FAIL kb_hold: READY=%b KBSR=%h KBDR=%h expected 0/8000/005A",
                     KB_READY, s, b);
        end
        ADDR      = KBDR;
        RD_STROBE = 1'b1;
        @(negedge CLK);
        RD_STROBE = 1'b0;
        read_reg(KBSR, s);
        read_reg(KBDR, b);
        checks++;
        if (KB_READY !== 1'b1 || s !== 16'h0000 || b !== 16'h005A) begin
            errors++;
            $display("FAIL kb_release: READY=%b KBSR=%h KBDR=%h expected 1/0000/005A",
                     KB_READY, s, b);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] d;
        int low;
        ADDR   = DDR;
        WDATA  = 16'h0000;
        MEM_WE = 1'b1;
        repeat (4) @(negedge CLK);
        MEM_WE = 1'b0;
        // Pop happened on the second write edge: now at start+2; move to the
        // middle of data bit 1.
        repeat (CPB + CPB + CPB / 2 - 2) @(negedge CLK);
        read_reg(DSR, d);
        checks++;
        if (TXD !== 1'b0 || d !== 16'h8000) begin
            errors++;
            $display("FAIL midframe: TXD=%b DSR=%h expected 0/8000", TXD, d);
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        read_reg(DSR, d);
        checks++;
        if (TXD !== 1'b1 || d !== 16'hC000) begin
            errors++;
            $display("FAIL reset_abort: TXD=%b DSR=%h expected 1/C000", TXD, d);
        end
        low = 0;
        for (int c = 0; c < 12 * CPB; c++) begin
            @(negedge CLK);
            if (TXD !== 1'b1) low++;
        end
        checks++;
        if (low != 0) begin
            errors++;
            $display("FAIL reset_no_frames: low_cycles=%0d expected 0", low);
        end
    endtask

    initial begin
        test_reset();
        test_unmapped();
        test_single_frame();
        test_back_to_back();
        test_keyboard();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
